// File: rtl/neuron_pkg.sv
// Shared types and helpers for the fully-connected neuron layer.
// Holds the FSM state encoding, index sizing and output saturation.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINISH
    } state_t;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Clamp a wide signed value into the range of a w-bit signed number.
    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/neuron_mac.sv
// One accumulator channel: truncating fixed-point MAC plus
// bias, optional ReLU and output saturation.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int INPUT_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int FRAC_BITS    = 5,
    parameter int ACC_WIDTH    = 18,
    parameter int OUT_WIDTH    = 8,
    parameter bit RELU_EN      = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          en,
    input  logic                          fin,
    input  logic signed [INPUT_WIDTH-1:0]  data_in,
    input  logic signed [WEIGHT_WIDTH-1:0] weight,
    input  logic signed [ACC_WIDTH-1:0]    bias,
    output logic signed [OUT_WIDTH-1:0]    result
);

    localparam int PW = INPUT_WIDTH + WEIGHT_WIDTH;

    logic signed [PW-1:0]        prod;
    logic signed [PW-1:0]        prod_sh;
    logic signed [ACC_WIDTH-1:0] term;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH:0]   sum;
    logic signed [ACC_WIDTH:0]   act;
    logic signed [63:0]          sat;

    // Arithmetic shift floors toward -inf, matching the fixed-point format.
    always_comb begin
        prod    = data_in * weight;
        prod_sh = prod >>> FRAC_BITS;
        term    = ACC_WIDTH'(prod_sh);
        sum     = {acc[ACC_WIDTH-1], acc} + {bias[ACC_WIDTH-1], bias};
        act     = sum;
        if (RELU_EN && sum[ACC_WIDTH]) act = '0;
        sat     = saturate(64'(act), OUT_WIDTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            result <= '0;
        end else begin
            if (clr) acc <= '0;
            else if (en) acc <= acc + term;
            if (fin) result <= sat[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/neuron_layer.sv
// Fully-connected layer: NUM_NEURONS MAC channels sharing one input
// stream, sequenced by a start/busy/valid FSM with an input stall.
module neuron_layer
    import neuron_pkg::*;
#(
    parameter int NUM_INPUTS   = 42,
    parameter int NUM_NEURONS  = 8,
    parameter int INPUT_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int FRAC_BITS    = 5,
    parameter int ACC_WIDTH    = 18,
    parameter int OUT_WIDTH    = 8,
    parameter bit RELU_EN      = 1'b1,
    localparam int IXW         = idx_width(NUM_INPUTS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                in_valid,
    input  logic [INPUT_WIDTH-1:0]              data_in,
    input  logic [NUM_NEURONS*WEIGHT_WIDTH-1:0] weight,
    input  logic [NUM_NEURONS*ACC_WIDTH-1:0]    bias,
    output logic [IXW-1:0]                      in_idx,
    output logic                                busy,
    output logic                                out_valid,
    output logic [NUM_NEURONS*OUT_WIDTH-1:0]    result
);

    localparam int ACC_MIN = INPUT_WIDTH + WEIGHT_WIDTH - FRAC_BITS
                           + $clog2(NUM_INPUTS) + 1;
    localparam logic [IXW-1:0] LAST = IXW'(NUM_INPUTS - 1);

    if (ACC_WIDTH < ACC_MIN) begin : g_acc_check
        $error("neuron_layer: ACC_WIDTH too narrow for NUM_INPUTS");
    end

    state_t state;
    logic   clr;
    logic   en;
    logic   fin;

    assign clr = (state == IDLE) && start;
    assign en  = (state == ACCUM) && in_valid;
    assign fin = (state == FINISH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_idx    <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= ACCUM;
                        in_idx <= '0;
                        busy   <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (in_idx == LAST) state <= FINISH;
                        else in_idx <= in_idx + 1'b1;
                    end
                end
                FINISH: begin
                    state     <= IDLE;
                    in_idx    <= '0;
                    busy      <= 1'b0;
                    out_valid <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_mac
        neuron_mac #(
            .INPUT_WIDTH (INPUT_WIDTH),
            .WEIGHT_WIDTH(WEIGHT_WIDTH),
            .FRAC_BITS   (FRAC_BITS),
            .ACC_WIDTH   (ACC_WIDTH),
            .OUT_WIDTH   (OUT_WIDTH),
            .RELU_EN     (RELU_EN)
        ) u_mac (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .en     (en),
            .fin    (fin),
            .data_in(data_in),
            .weight (weight[n*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
            .bias   (bias[n*ACC_WIDTH +: ACC_WIDTH]),
            .result (result[n*OUT_WIDTH +: OUT_WIDTH])
        );
    end

endmodule

// File: tb/tb_neuron_layer.sv
// Directed bench for neuron_layer: ReLU and linear instances share
// stimulus; results, latency, stalls, reset abort and start handling.
module tb_neuron_layer;

    localparam int NI = 42;
    localparam int NN = 8;
    localparam int IW = 8;
    localparam int WW = 8;
    localparam int AW = 18;
    localparam int OW = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic [IW-1:0]    data_in;
    logic [NN*WW-1:0] weight;
    logic [NN*AW-1:0] bias;
    logic [5:0]       idx1, idx0;
    logic             busy1, busy0;
    logic             ov1, ov0;
    logic [NN*OW-1:0] res1, res0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    neuron_layer #(.RELU_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .data_in(data_in), .weight(weight), .bias(bias),
        .in_idx(idx1), .busy(busy1), .out_valid(ov1), .result(res1)
    );

    neuron_layer #(.RELU_EN(1'b0)) dut_lin (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .data_in(data_in), .weight(weight), .bias(bias),
        .in_idx(idx0), .busy(busy0), .out_valid(ov0), .result(res0)
    );

    typedef struct {
        string name;
        int    d;
        int    w;
        int    b;
        int    e_relu;
        int    e_lin;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic set_uniform(input int d, input int w, input int b);
        data_in = IW'(d);
        for (int n = 0; n < NN; n++) begin
            weight[n*WW +: WW] = WW'(w);
            bias[n*AW +: AW]   = AW'(b);
        end
    endtask

    task automatic check_results(input string tag, input int e1,
                                 input int e0);
        for (int n = 0; n < NN; n++) begin
            chk($sformatf("%s_relu_n%0d", tag, n),
                int'($signed(res1[n*OW +: OW])), e1);
            chk($sformatf("%s_lin_n%0d", tag, n),
                int'($signed(res0[n*OW +: OW])), e0);
        end
    endtask

    // Call at a negedge just after start was accepted or raised.
    task automatic wait_done(input int n0, input int stall_at,
                             input int stall_len, input int repulse_at,
                             output int n);
        n = n0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = 1'b0;
            if (n == 1) chk("busy_on", int'(busy1), 1);
            if (n == repulse_at) start = 1'b1;
            if (stall_len > 0 && n == stall_at) in_valid = 1'b0;
            if (stall_len > 0 && n > stall_at && n <= stall_at + stall_len)
                chk($sformatf("stall_idx_c%0d", n), int'(idx1), stall_at - 1);
            if (stall_len > 0 && n == stall_at + stall_len) in_valid = 1'b1;
            if (ov1) break;
        end
        chk("done_before_timeout", int'(ov1), 1);
        chk("busy_off_at_valid", int'(busy1), 0);
        chk("lin_valid_aligned", int'(ov0), 1);
    endtask

    task automatic run_vec(input int d, input int w, input int b,
                           input int stall_at, input int stall_len,
                           input int repulse_at, output int n);
        set_uniform(d, w, b);
        in_valid = 1'b1;
        start    = 1'b1;
        wait_done(0, stall_at, stall_len, repulse_at, n);
    endtask

    initial begin
        int n;
        int ov_seen;
        int lane_exp[NN];

        tbl[0] = '{"ones",      1,   32,   16,  58,   58};
        tbl[1] = '{"neg_floor", -1,  1,    0,   0,    -42};
        tbl[2] = '{"sat_hi",    127, 127,  0,   127,  127};
        tbl[3] = '{"sat_lo",    127, -128, 0,   0,    -128};
        tbl[4] = '{"small_neg", 5,   -3,   20,  0,    -22};
        tbl[5] = '{"big_pos",   64,  16,   -100, 127, 127};
        tbl[6] = '{"mid",       3,   11,   -5,  37,   37};
        tbl[7] = '{"bias_only", 0,   5,    -300, 0,   -128};
        lane_exp = '{0, 42, 84, 126, 127, 127, 127, 127};

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        weight   = '0;
        bias     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_idx", int'(idx1), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_valid", int'(ov1), 0);
        chk("rst_result", int'(res1), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i].d, tbl[i].w, tbl[i].b, 0, 0, 0, n);
            chk({tbl[i].name, "_latency"}, n, 44);
            check_results(tbl[i].name, tbl[i].e_relu, tbl[i].e_lin);
            @(negedge clk);
        end

        // Per-lane weights: neuron n gets weight n with input 1.0.
        data_in = IW'(32);
        for (int k = 0; k < NN; k++) begin
            weight[k*WW +: WW] = WW'(k);
            bias[k*AW +: AW]   = '0;
        end
        in_valid = 1'b1;
        start    = 1'b1;
        wait_done(0, 0, 0, 0, n);
        for (int k = 0; k < NN; k++) begin
            chk($sformatf("lane_relu_n%0d", k),
                int'($signed(res1[k*OW +: OW])), lane_exp[k]);
            chk($sformatf("lane_lin_n%0d", k),
                int'($signed(res0[k*OW +: OW])), lane_exp[k]);
        end
        @(negedge clk);

        // Three stall cycles while in_idx sits at 10.
        run_vec(1, 32, 16, 11, 3, 0, n);
        chk("stall_latency", n, 47);
        check_results("stall", 58, 58);
        @(negedge clk);

        // start pulsed mid-run is ignored.
        run_vec(3, 11, -5, 0, 0, 5, n);
        chk("repulse_latency", n, 44);
        check_results("repulse", 37, 37);

        // start in the out_valid cycle begins a new run.
        set_uniform(-1, 1, 0);
        in_valid = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("coinc_busy", int'(busy1), 1);
        chk("coinc_no_valid", int'(ov1), 0);
        check_results("coinc_hold", 37, 37);
        wait_done(1, 0, 0, 0, n);
        chk("coinc_latency", n, 44);
        check_results("coinc", 0, -42);
        @(negedge clk);

        // Reset while in_idx is 20 aborts the run.
        set_uniform(127, 127, 0);
        in_valid = 1'b1;
        start    = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort_idx", int'(idx1), 20);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_idx_clr", int'(idx1), 0);
        chk("abort_busy", int'(busy1), 0);
        chk("abort_valid", int'(ov1), 0);
        chk("abort_res_relu", int'(res1), 0);
        chk("abort_res_lin", int'(res0), 0);
        ov_seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (ov1 || ov0) ov_seen++;
        end
        chk("abort_no_valid", ov_seen, 0);
        run_vec(1, 32, 16, 0, 0, 0, n);
        chk("after_abort_latency", n, 44);
        check_results("after_abort", 58, 58);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
